seq_serializer: RTL and testbench
=================================

Name: seq_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the 1011 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and buffers up to 2 words.
- Emits one bit per clk on ser_o, which drives the detector's data_i.
- Back-to-back words stream with no idle gap. When no word is in flight, ser_o carries IDLE_BIT.

Parameters:
- WIDTH, 8, word width in bits (>=2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first; 0 = bit 0 shifted first.
- IDLE_BIT, 0, value driven on ser_o when no word is in flight.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_data  in  WIDTH  parallel word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  buffer can accept a word this cycle.
- ser_o  out  1  serial bit stream to the detector.
- ser_valid_o  out  1  ser_o carries a data bit (not idle fill).
- busy_o  out  1  buffer non-empty or shifter active.
- words_sent_o  out  16  count of fully shifted words, wraps at 2^16.

Behaviour:
- Reset values (async assert, sync release): ser_o=IDLE_BIT, ser_valid_o=0, busy_o=0, words_sent_o=0, FIFO empty, in_ready=1, FSM=IDLE, bit counter=0. Reset mid-word discards the word in flight and all buffered words.
- Input buffer: 2-entry FIFO.
  - in_ready = !full. It depends only on registered state, with no combinational path from in_valid.
  - A push occurs on a clk edge when in_valid && in_ready. Words are kept in strict order.
  - in_data is sampled only at the push edge.
- Push and pop in the same cycle are allowed whenever the FIFO is non-full. Occupancy is unchanged.
- FSM states:
  - IDLE: no word in flight. ser_o=IDLE_BIT, ser_valid_o=0.
    - IDLE->SHIFT when the FIFO is non-empty at an edge: pop the head into the shift register, bit counter=0, present the first bit.
  - SHIFT: ser_o = current bit from the shift register (registered output), ser_valid_o=1.
    - Each edge with counter<WIDTH-1: shift one position, counter+1.
    - Edge with counter==WIDTH-1 (last bit presented):
      - words_sent_o+1, wrapping.
      - If the FIFO is non-empty: pop and load the next word, counter=0, stay in SHIFT. This gives a gapless stream.
      - Otherwise go to IDLE.
- Latency: a word pushed at edge N into an empty block presents its first bit after edge N+1 and its last bit after edge N+WIDTH.
- Throughput: 1 word per WIDTH cycles.
  - A steady producer sees in_ready toggle as the FIFO fills and drains.
  - Neither a push nor a pop is lost on simultaneous events.
- Bit order:
  - MSB_FIRST=1: in_data[WIDTH-1] first, down to in_data[0].
  - MSB_FIRST=0: in_data[0] first.
- busy_o = (FSM==SHIFT) || FIFO non-empty. It is registered/derived from state only.
- in_valid while in_ready=0: the word is not accepted, and the producer must hold it. This block never drops an offered word.
- ser_o changes only on clk edges; it is glitch-free for the detector's sampling.

Test Plan:
- Reset, then push 0xB0 (MSB_FIRST=1) -> ser_o = 1,0,1,1,0,0,0,0 on consecutive cycles starting 2 edges after the push. ser_valid_o high for exactly 8 cycles. Downstream detector fires once. words_sent_o=1.
- Push 3 words 0xFF, 0x00, 0xA5 with in_valid held high -> 24 contiguous ser_valid_o cycles with no gap. in_ready deasserts while the FIFO is full. Output order preserved. words_sent_o=3.
- MSB_FIRST=0, push 0x0D -> ser_o = 1,0,1,1,0,0,0,0.
- Idle stream with no pushes for 20 cycles -> ser_o=IDLE_BIT (0), ser_valid_o=0, busy_o=0, in_ready=1 throughout.
- Assert rst_n=0 at bit 3 of a word with one word buffered -> all outputs immediately return to reset values. After release no residual bits appear and words_sent_o=0.
- Producer holds in_valid with changing in_data while in_ready=0 -> only the values present on accept edges are serialized; no duplicates or omissions.

Source files
------------

// File: rtl/seq_serializer.sv
// seq_serializer: parallel-in/serial-out stage feeding the 1011 sequence detector.
// Words enter through a 2-entry FIFO over a valid/ready handshake and leave one
// bit per clock on ser_o. Consecutive words are streamed with no idle gap.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   in_data       WIDTH-bit parallel word, sampled on the push edge
//   in_valid      in_data valid
//   in_ready      FIFO not full (registered)
//   ser_o         serial bit, IDLE_BIT when no word is in flight
//   ser_valid_o   ser_o carries a data bit
//   busy_o        FIFO non-empty or shifter active
//   words_sent_o  count of fully shifted words, wraps at 2^16
module seq_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_o,
  output logic             ser_valid_o,
  output logic             busy_o,
  output logic [15:0]      words_sent_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned OCC_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mem_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [15:0]        words_d;
  logic               ser_d, ser_valid_d, busy_d, ready_d;
  logic               push_c, pop_c, empty_c, last_c;
  logic [WIDTH-1:0]   head_c;

  // Arrange a word so the first bit to send always sits in the MSB of the shifter.
  function automatic logic [WIDTH-1:0] order_bits(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = w;
    if (!MSB_FIRST) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r[i] = w[WIDTH-1-i];
      end
    end
    return r;
  endfunction

  assign push_c  = in_valid && in_ready;
  assign empty_c = (count_q == OCC_W'(0));
  assign last_c  = (bit_cnt_q == CNT_W'(WIDTH - 1));
  assign head_c  = mem_q[rd_ptr_q];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, pop decision and next values of all registered outputs
  always_comb begin
    state_d   = state_q;
    pop_c     = 1'b0;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    words_d   = words_sent_o;
    count_d   = count_q;

    case (state_q)
      ST_IDLE: begin
        if (!empty_c) begin
          pop_c     = 1'b1;
          sreg_d    = order_bits(head_c);
          bit_cnt_d = CNT_W'(0);
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!last_c) begin
          sreg_d    = sreg_q << 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else begin
          words_d = words_sent_o + 16'd1;
          // Reload straight from the FIFO so the stream stays gapless.
          if (!empty_c) begin
            pop_c     = 1'b1;
            sreg_d    = order_bits(head_c);
            bit_cnt_d = CNT_W'(0);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase

    ser_d       = (state_d == ST_SHIFT) ? sreg_d[WIDTH-1] : IDLE_BIT;
    ser_valid_d = (state_d == ST_SHIFT);
    busy_d      = (state_d == ST_SHIFT) || (count_d != OCC_W'(0));
    ready_d     = (count_d != OCC_W'(2));
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Shifter, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      words_sent_o <= '0;
      ser_o        <= IDLE_BIT;
      ser_valid_o  <= 1'b0;
      busy_o       <= 1'b0;
      in_ready     <= 1'b1;
    end else begin
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      words_sent_o <= words_d;
      ser_o        <= ser_d;
      ser_valid_o  <= ser_valid_d;
      busy_o       <= busy_d;
      in_ready     <= ready_d;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: one MSB-first and one LSB-first instance, scoreboard
// of expected serial bits built from words at their accept edges, plus
// hand-written expectations for latency, burst, idle, hold and reset cases.
module tb_seq_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0]  m_in_data = '0, l_in_data = '0;
  logic        m_in_valid = 1'b0, l_in_valid = 1'b0;
  logic        m_in_ready, l_in_ready;
  logic        m_ser, l_ser, m_sv, l_sv, m_busy, l_busy;
  logic [15:0] m_words, l_words;

  int total = 0;
  int bad   = 0;

  // Written only by the monitors
  logic exp_m[$], obs_m[$], exp_l[$], obs_l[$];
  int   vcnt_m = 0, rise_m = 0, det_m = 0, rdylow_m = 0;
  // Read positions, owned by the main process
  int   eidx_m = 0, oidx_m = 0, eidx_l = 0, oidx_l = 0;

  typedef struct {
    bit         sel;      // 0 = MSB-first instance, 1 = LSB-first instance
    logic [7:0] data;
    logic [7:0] exp_ser;  // expected bits, first-sent bit leftmost
  } vec_t;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_data(m_in_data), .in_valid(m_in_valid),
    .in_ready(m_in_ready), .ser_o(m_ser), .ser_valid_o(m_sv),
    .busy_o(m_busy), .words_sent_o(m_words)
  );

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(l_in_data), .in_valid(l_in_valid),
    .in_ready(l_in_ready), .ser_o(l_ser), .ser_valid_o(l_sv),
    .busy_o(l_busy), .words_sent_o(l_words)
  );

  // MSB-first monitor: records observed bits, expected bits at accept, stats
  initial begin
    logic       prev;
    logic [3:0] sh;
    prev = 1'b0;
    sh   = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m_sv) begin
          obs_m.push_back(m_ser);
          vcnt_m++;
          if (!prev) rise_m++;
          sh = {sh[2:0], m_ser};
          if (sh == 4'b1011) det_m++;
        end
        prev = m_sv;
        if (!m_in_ready) rdylow_m++;
        if (m_in_valid && m_in_ready)
          for (int i = 0; i < 8; i++) exp_m.push_back(m_in_data[7-i]);
      end else begin
        prev = 1'b0;
        sh   = '0;
      end
    end
  end

  // LSB-first monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (l_sv) obs_l.push_back(l_ser);
        if (l_in_valid && l_in_ready)
          for (int i = 0; i < 8; i++) exp_l.push_back(l_in_data[i]);
      end
    end
  end

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Offer a word and return #1 after the edge that accepted it; valid stays high.
  task automatic push(input bit sel, input logic [7:0] d);
    int n;
    n = 0;
    if (sel) begin l_in_valid = 1'b1; l_in_data = d; end
    else     begin m_in_valid = 1'b1; m_in_data = d; end
    while (!(sel ? l_in_ready : m_in_ready) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) check("push_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input bit sel);
    int n;
    n = 0;
    while ((sel ? l_busy : m_busy) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) check("idle_timeout", 1, 0);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_stream(input bit sel, input string name);
    int ne, no, nmin;
    if (!sel) begin
      ne = exp_m.size() - eidx_m;
      no = obs_m.size() - oidx_m;
      check({name, "_len"}, no, ne);
      nmin = (ne < no) ? ne : no;
      for (int i = 0; i < nmin; i++)
        check({name, "_bit"}, 32'(obs_m[oidx_m+i]), 32'(exp_m[eidx_m+i]));
      eidx_m = exp_m.size();
      oidx_m = obs_m.size();
    end else begin
      ne = exp_l.size() - eidx_l;
      no = obs_l.size() - oidx_l;
      check({name, "_len"}, no, ne);
      nmin = (ne < no) ? ne : no;
      for (int i = 0; i < nmin; i++)
        check({name, "_bit"}, 32'(obs_l[oidx_l+i]), 32'(exp_l[eidx_l+i]));
      eidx_l = exp_l.size();
      oidx_l = obs_l.size();
    end
  endtask

  task automatic resync();
    eidx_m = exp_m.size();
    oidx_m = obs_m.size();
    eidx_l = exp_l.size();
    oidx_l = obs_l.size();
  endtask

  task automatic do_reset();
    m_in_valid = 1'b0;
    l_in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resync();
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[8];
    int         snap_v, snap_r, snap_d, snap_o, base, k, n;
    bit         acc;
    logic [7:0] w, cap;
    logic [7:0] hold_words[5];

    vecs[0] = '{1'b1, 8'h0D, 8'b1011_0000};
    vecs[1] = '{1'b1, 8'h01, 8'b1000_0000};
    vecs[2] = '{1'b1, 8'h80, 8'b0000_0001};
    vecs[3] = '{1'b1, 8'hF0, 8'b0000_1111};
    vecs[4] = '{1'b1, 8'h2C, 8'b0011_0100};
    vecs[5] = '{1'b0, 8'hB0, 8'b1011_0000};
    vecs[6] = '{1'b0, 8'h6E, 8'b0110_1110};
    vecs[7] = '{1'b0, 8'h01, 8'b0000_0001};
    hold_words[0] = 8'hC3; hold_words[1] = 8'h5A; hold_words[2] = 8'h96;
    hold_words[3] = 8'h3C; hold_words[4] = 8'hE1;

    // Reset values while rst_n is held low
    #12;
    check("rst_ser", 32'(m_ser), 0);
    check("rst_sv", 32'(m_sv), 0);
    check("rst_busy", 32'(m_busy), 0);
    check("rst_ready", 32'(m_in_ready), 1);
    check("rst_words", 32'(m_words), 0);
    check("rst_lsb_ready", 32'(l_in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle stream: {ser_valid, ser, busy, ready} must stay 0001
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", 32'({m_sv, m_ser, m_busy, m_in_ready}), 32'(4'b0001));
    end
    @(posedge clk); #1;

    // Single word latency: push 0xB0 at edge N
    snap_d = det_m;
    push(1'b0, 8'hB0);
    m_in_valid = 1'b0;
    check("lat_sv_n", 32'(m_sv), 0);
    check("lat_busy_n", 32'(m_busy), 1);
    @(posedge clk); #1;
    check("lat_sv_first", 32'(m_sv), 1);
    check("lat_ser_first", 32'(m_ser), 1);
    repeat (7) @(posedge clk);
    #1;
    check("lat_sv_last", 32'(m_sv), 1);
    check("lat_ser_last", 32'(m_ser), 0);
    @(posedge clk); #1;
    check("lat_sv_after", 32'(m_sv), 0);
    check("lat_words", 32'(m_words), 1);
    check("lat_busy_after", 32'(m_busy), 0);
    check("lat_detect", det_m - snap_d, 1);
    check_stream(1'b0, "lat_stream");

    // Back-to-back burst with in_valid held high
    do_reset();
    snap_v = vcnt_m; snap_r = rise_m; snap_o = rdylow_m;
    push(1'b0, 8'hFF);
    push(1'b0, 8'h00);
    push(1'b0, 8'hA5);
    m_in_valid = 1'b0;
    wait_idle(1'b0);
    check("burst_valid_cycles", vcnt_m - snap_v, 24);
    check("burst_runs", rise_m - snap_r, 1);
    check("burst_ready_low", 32'(rdylow_m > snap_o), 1);
    check("burst_words", 32'(m_words), 3);
    check_stream(1'b0, "burst_stream");

    // Table of single words on both bit orders
    for (int v = 0; v < 8; v++) begin
      push(vecs[v].sel, vecs[v].data);
      m_in_valid = 1'b0;
      l_in_valid = 1'b0;
      wait_idle(vecs[v].sel);
      cap = '0;
      n = vecs[v].sel ? obs_l.size() : obs_m.size();
      if (n >= 8) begin
        for (int j = 0; j < 8; j++)
          cap = {cap[6:0], (vecs[v].sel ? obs_l[n-8+j] : obs_m[n-8+j])};
      end
      check("table_word", 32'(cap), 32'(vecs[v].exp_ser));
      check_stream(vecs[v].sel, "table_stream");
    end

    // Producer holds in_valid and scrambles in_data while in_ready is low
    do_reset();
    k = 0;
    n = 0;
    while (k < 5 && n < 400) begin
      m_in_valid = 1'b1;
      if (m_in_ready) begin
        m_in_data = hold_words[k];
        acc = 1'b1;
      end else begin
        m_in_data = 8'($urandom);
        acc = 1'b0;
      end
      @(posedge clk); #1;
      if (acc) k++;
      n++;
    end
    m_in_valid = 1'b0;
    check("hold_accepted", k, 5);
    wait_idle(1'b0);
    base = oidx_m;
    check("hold_bits", obs_m.size() - base, 40);
    for (int i = 0; i < 5; i++) begin
      w = '0;
      if (obs_m.size() >= base + 8 * (i + 1))
        for (int j = 0; j < 8; j++) w = {w[6:0], obs_m[base+8*i+j]};
      check("hold_word", 32'(w), 32'(hold_words[i]));
    end
    check("hold_words_sent", 32'(m_words), 5);
    check_stream(1'b0, "hold_stream");

    // Reset at bit 3 of a word with a second word buffered
    do_reset();
    push(1'b0, 8'hB4);
    push(1'b0, 8'h69);
    m_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_sv_before", 32'(m_sv), 1);
    check("mid_busy_before", 32'(m_busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ser", 32'(m_ser), 0);
    check("mid_rst_sv", 32'(m_sv), 0);
    check("mid_rst_busy", 32'(m_busy), 0);
    check("mid_rst_ready", 32'(m_in_ready), 1);
    check("mid_rst_words", 32'(m_words), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resync();
    snap_o = obs_m.size();
    repeat (20) @(negedge clk);
    check("mid_no_residual", obs_m.size() - snap_o, 0);
    check("mid_words_after", 32'(m_words), 0);
    check("mid_busy_after", 32'(m_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
